// File: rtl/mcyc_bus_checker.sv
// mcyc_bus_checker: follows the SM83 T-states from an instruction start and compares
// each M-cycle's bus access against a programmable table of expected accesses.
// Optional feature macro: BUS_HOLD_CHECK_EN (address must hold after the ADR_T sample).
module mcyc_bus_checker #(
    parameter int unsigned ADR_W  = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADR_T  = 2,
    parameter int unsigned DATA_T = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADR_W-1:0]           cpu_adr,
    input  logic                       cpu_rd,
    input  logic                       cpu_wr,
    input  logic [DATA_W-1:0]          cpu_dout,
    input  logic [DATA_W-1:0]          cpu_din,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
    input  logic [1:0]                 cfg_kind,
    input  logic [ADR_W-1:0]           cfg_adr,
    input  logic [DATA_W-1:0]          cfg_data,
    input  logic                       cfg_data_en,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [2:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   err_mcyc,
    output logic [$clog2(DEPTH)-1:0]   mcyc,
    output logic [1:0]                 tstate
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = IDX_W + 1;

    localparam logic [1:0] K_DC  = 2'd0;
    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_WR  = 2'd2;
    localparam logic [1:0] K_INT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         tstate_q, tstate_d;
    logic [IDX_W-1:0]   mcyc_q, mcyc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [2:0]         err_code_q, err_code_d;
    logic [IDX_W-1:0]   err_mcyc_q, err_mcyc_d;

    // Expectation table; deliberately not reset so it survives a reset.
    logic [1:0]         tbl_kind_q [DEPTH];
    logic [ADR_W-1:0]   tbl_adr_q  [DEPTH];
    logic [DATA_W-1:0]  tbl_data_q [DEPTH];
    logic               tbl_den_q  [DEPTH];

    logic               accept;
    logic               chk_en;
    logic               tbl_we;
    logic [1:0]         cur_t;
    logic [IDX_W-1:0]   cur_m;
    logic [LEN_W-1:0]   len_clamp;
    logic [1:0]         ent_kind;
    logic [ADR_W-1:0]   ent_adr;
    logic [DATA_W-1:0]  ent_data;
    logic               ent_den;
    logic               at_adr, at_data, is_rw;
    logic               f_adr, f_strb, f_data, f_int, f_hold, f_busy;

`ifdef BUS_HOLD_CHECK_EN
    logic [ADR_W-1:0]   adr_hold_q, adr_hold_d;
    logic               hold_act_q, hold_act_d;
`endif

    assign ent_kind = tbl_kind_q[cur_m];
    assign ent_adr  = tbl_adr_q[cur_m];
    assign ent_data = tbl_data_q[cur_m];
    assign ent_den  = tbl_den_q[cur_m];

    // Next-state, T-state/M-cycle sequencing, bus comparison and first-error capture.
    always_comb begin
        state_d    = state_q;
        tstate_d   = tstate_q;
        mcyc_d     = mcyc_q;
        len_d      = len_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_mcyc_d = err_mcyc_q;
        accept     = 1'b0;
        chk_en     = 1'b0;
        cur_t      = 2'd0;
        cur_m      = '0;
        len_clamp  = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    len_d    = len_clamp;
                    tstate_d = 2'd0;
                    mcyc_d   = '0;
                    if (len_clamp == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // The start cycle itself is M0/T1 and is checked.
                        chk_en   = 1'b1;
                        state_d  = S_RUN;
                        busy_d   = 1'b1;
                        tstate_d = 2'd1;
                    end
                end
            end
            S_RUN: begin
                chk_en   = 1'b1;
                cur_t    = tstate_q;
                cur_m    = mcyc_q;
                busy_d   = 1'b1;
                tstate_d = tstate_q + 2'd1;
                if (tstate_q == 2'd3) begin
                    if (LEN_W'(mcyc_q) == len_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        mcyc_d  = '0;
                    end else begin
                        mcyc_d = mcyc_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                tstate_d = 2'd0;
                mcyc_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        tbl_we  = cfg_we && (state_q != S_RUN) && !accept;

        at_adr  = chk_en && (cur_t == 2'(ADR_T - 1));
        at_data = chk_en && (cur_t == 2'(DATA_T - 1));
        is_rw   = (ent_kind == K_RD) || (ent_kind == K_WR);

        f_adr   = at_adr && is_rw && (cpu_adr != ent_adr);
        f_strb  = at_adr && (((ent_kind == K_RD) && !(cpu_rd && !cpu_wr)) ||
                             ((ent_kind == K_WR) && !(cpu_wr && !cpu_rd)));
        f_data  = at_data && ent_den &&
                  (((ent_kind == K_WR) && (cpu_dout != ent_data)) ||
                   ((ent_kind == K_RD) && (cpu_din  != ent_data)));
        f_int   = at_adr && (ent_kind == K_INT) && (cpu_rd || cpu_wr);
        f_busy  = (state_q == S_RUN) && start;

`ifdef BUS_HOLD_CHECK_EN
        adr_hold_d = adr_hold_q;
        hold_act_d = chk_en && hold_act_q && (cur_t != 2'd3);
        f_hold     = chk_en && hold_act_q && (cpu_adr != adr_hold_q);
        if (at_adr && is_rw) begin
            adr_hold_d = cpu_adr;
            hold_act_d = (cur_t != 2'd3);
        end
`else
        f_hold = 1'b0;
`endif

        if (accept) begin
            err_d      = 1'b0;
            err_code_d = 3'd0;
            err_mcyc_d = '0;
        end

        // Only the first error is kept; within a cycle the lowest code wins.
        if (!err_d && (f_adr || f_strb || f_data || f_int || f_hold || f_busy)) begin
            err_d      = 1'b1;
            err_mcyc_d = cur_m;
            if (f_adr)       err_code_d = 3'd1;
            else if (f_strb) err_code_d = 3'd2;
            else if (f_data) err_code_d = 3'd3;
            else if (f_int)  err_code_d = 3'd4;
            else if (f_hold) err_code_d = 3'd5;
            else             err_code_d = 3'd6;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tstate_q   <= 2'd0;
            mcyc_q     <= '0;
            len_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
            err_mcyc_q <= '0;
`ifdef BUS_HOLD_CHECK_EN
            adr_hold_q <= '0;
            hold_act_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tstate_q   <= tstate_d;
            mcyc_q     <= mcyc_d;
            len_q      <= len_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_mcyc_q <= err_mcyc_d;
`ifdef BUS_HOLD_CHECK_EN
            adr_hold_q <= adr_hold_d;
            hold_act_q <= hold_act_d;
`endif
        end
    end

    // Table write port, locked while a check is running.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_kind_q[cfg_idx] <= cfg_kind;
            tbl_adr_q[cfg_idx]  <= cfg_adr;
            tbl_data_q[cfg_idx] <= cfg_data;
            tbl_den_q[cfg_idx]  <= cfg_data_en;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_mcyc = err_mcyc_q;
    assign mcyc     = mcyc_q;
    assign tstate   = tstate_q;

endmodule
